// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Valid/ready read port carrying one received frame and its flags.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] m_data;
    logic                 m_frame_err;
    logic                 m_parity_err;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_frame_err,
        output m_parity_err,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_frame_err,
        input  m_parity_err,
        input  m_valid,
        output m_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : UART receiver with parity/framing checks feeding a FWFT FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 8,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire                                 clk,
    input  wire                                 rst_n,
    input  wire                                 rx,
    uart_rx_fifo_if.master                      m_if,
    output logic                                overrun,
    input  wire                                 clr_overrun,
    output logic                                busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_count
);
    localparam int   c_cntw    = $clog2(CLKS_PER_BIT);
    localparam int   c_half    = CLKS_PER_BIT / 2;
    localparam int   c_aw      = $clog2(FIFO_DEPTH);
    localparam int   c_cw      = $clog2(FIFO_DEPTH + 1);
    localparam int   c_ww      = DATA_BITS + 2;
    localparam logic c_par_odd = (PARITY == 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    logic                 r_sync1, r_rx_s, r_rx_d;
    state_t               r_state;
    logic [c_cntw-1:0]    r_cnt;
    logic [3:0]           r_bitcnt;
    logic                 r_stopcnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par, r_perr, r_ferr;

    logic [c_ww-1:0]      r_mem [FIFO_DEPTH];
    logic [c_aw-1:0]      r_wptr, r_rptr;
    logic [c_cw-1:0]      r_count;
    logic                 r_overrun;

    logic                 w_frame_done, w_ferr_new, w_full, w_pop, w_push, w_valid;
    logic [c_ww-1:0]      w_head;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // r_cnt counts down to the next mid-bit sample; zero marks a sample edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_stopcnt <= 1'b0;
            r_shift   <= '0;
            r_par     <= 1'b0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_rx_d && !r_rx_s) begin
                        r_state <= S_START;
                        r_cnt   <= c_cntw'(c_half - 1);
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        r_state  <= r_rx_s ? S_IDLE : S_DATA;
                        r_cnt    <= c_cntw'(CLKS_PER_BIT - 1);
                        r_bitcnt <= '0;
                        r_par    <= 1'b0;
                        r_perr   <= 1'b0;
                        r_ferr   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_cntw'(1);
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_par   <= r_par ^ r_rx_s;
                        r_cnt   <= c_cntw'(CLKS_PER_BIT - 1);
                        if (r_bitcnt == 4'(DATA_BITS - 1)) begin
                            r_state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                            r_stopcnt <= 1'b0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 4'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cntw'(1);
                    end
                end
                S_PARITY: begin
                    if (r_cnt == '0) begin
                        r_perr    <= ((r_par ^ r_rx_s) != c_par_odd);
                        r_state   <= S_STOP;
                        r_stopcnt <= 1'b0;
                        r_cnt     <= c_cntw'(CLKS_PER_BIT - 1);
                    end else begin
                        r_cnt <= r_cnt - c_cntw'(1);
                    end
                end
                S_STOP: begin
                    if (r_cnt == '0) begin
                        r_ferr <= w_ferr_new;
                        if (r_stopcnt == 1'(STOP_BITS - 1)) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_stopcnt <= 1'b1;
                            r_cnt     <= c_cntw'(CLKS_PER_BIT - 1);
                        end
                    end else begin
                        r_cnt <= r_cnt - c_cntw'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign w_frame_done = (r_state == S_STOP) && (r_cnt == '0) &&
                          (r_stopcnt == 1'(STOP_BITS - 1));
    assign w_ferr_new   = r_ferr | ~r_rx_s;

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_valid = (r_count != '0);
    assign w_full  = (r_count == c_cw'(FIFO_DEPTH));
    assign w_pop   = w_valid && m_if.m_ready;
    assign w_push  = w_frame_done && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {r_perr, w_ferr_new, r_shift};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + c_aw'(1);
            if (w_pop)  r_rptr <= r_rptr + c_aw'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
            if (w_frame_done && w_full && !w_pop) begin
                r_overrun <= 1'b1;
            end else if (clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign w_head              = r_mem[r_rptr];
    assign m_if.m_valid        = w_valid;
    assign m_if.m_data         = w_valid ? w_head[DATA_BITS-1:0] : '0;
    assign m_if.m_frame_err    = w_valid & w_head[DATA_BITS];
    assign m_if.m_parity_err   = w_valid & w_head[DATA_BITS+1];
    assign overrun             = r_overrun;
    assign busy                = (r_state != S_IDLE);
    assign fifo_count          = r_count;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo (8E1, depth 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;
    localparam int c_cpb = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       clr_overrun = 1'b0;
    logic       overrun, busy;
    logic [2:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pops   = 0;
    int pops0;

    uart_rx_fifo_if #(.DATA_BITS(8)) bus ();

    uart_rx_fifo #(
        .CLKS_PER_BIT(c_cpb), .DATA_BITS(8), .PARITY(2),
        .STOP_BITS(1), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .m_if(bus),
        .overrun(overrun), .clr_overrun(clr_overrun),
        .busy(busy), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.m_valid && bus.m_ready) n_pops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller is positioned on a falling clock edge; each bit lasts c_cpb cycles.
    task automatic send_bit(input logic b);
        rx = b;
        repeat (c_cpb) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    // Sends one frame and checks the entry seen during the single cycle it is valid.
    task automatic recv_check(input string tag, input logic [7:0] d, input logic p,
                              input logic s, input logic exp_fe, input logic exp_pe,
                              output int lat);
        bit found;
        found = 0;
        lat   = 0;
        fork
            send_frame(d, p, s);
            begin
                for (int n = 1; n <= 120; n++) begin
                    @(negedge clk);
                    if (bus.m_valid && !found) begin
                        found = 1;
                        lat   = n;
                        check({tag, "_data"}, bus.m_data, d);
                        check({tag, "_ferr"}, bus.m_frame_err, exp_fe);
                        check({tag, "_perr"}, bus.m_parity_err, exp_pe);
                        break;
                    end
                end
                if (!found) check({tag, "_timeout"}, 32'd0, 32'd1);
            end
        join
    endtask

    initial begin
        int lat;
        bus.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_valid", bus.m_valid, 0);
        check("rst_data", bus.m_data, 0);
        check("rst_ferr", bus.m_frame_err, 0);
        check("rst_perr", bus.m_parity_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);

        // Valid frame: stop sample lands 87 cycles after the start edge is driven.
        pops0 = n_pops;
        recv_check("a5", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        check("a5_latency", lat, 87);
        check("a5_after_valid", bus.m_valid, 0);
        check("a5_pops", n_pops - pops0, 1);
        repeat (4) @(negedge clk);

        recv_check("perr", 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, lat);
        repeat (4) @(negedge clk);

        // Framing error, line held low, then released: one entry only.
        pops0 = n_pops;
        recv_check("ferr", 8'h7E, 1'b0, 1'b0, 1'b1, 1'b0, lat);
        repeat (20) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("ferr_no_retrigger", n_pops - pops0, 1);
        check("ferr_busy", busy, 0);
        recv_check("clean3c", 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        repeat (10) @(negedge clk);
        check("ferr_total_pops", n_pops - pops0, 2);

        // Glitch of 3 cycles: false start.
        pops0 = n_pops;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        check("glitch_busy_hi", busy, 1);
        repeat (5) @(negedge clk);
        check("glitch_busy_lo", busy, 0);
        repeat (30) @(negedge clk);
        check("glitch_pops", n_pops - pops0, 0);
        check("glitch_count", fifo_count, 0);

        // Overrun with consumer stalled; frames sent back to back.
        bus.m_ready = 1'b0;
        send_frame(8'h10, 1'b1, 1'b1);
        send_frame(8'h11, 1'b0, 1'b1);
        send_frame(8'h12, 1'b0, 1'b1);
        send_frame(8'h13, 1'b1, 1'b1);
        send_frame(8'h14, 1'b0, 1'b1);
        repeat (4) @(negedge clk);
        check("ovr_count", fifo_count, 4);
        check("ovr_flag", overrun, 1);
        for (int i = 0; i < 4; i++) begin
            check("drain_data", bus.m_data, 32'h10 + i);
            check("drain_flags", {bus.m_parity_err, bus.m_frame_err}, 0);
            bus.m_ready = 1'b1;
            @(negedge clk);
            bus.m_ready = 1'b0;
        end
        check("drain_empty", bus.m_valid, 0);
        check("drain_data_zero", bus.m_data, 0);
        check("ovr_sticky", overrun, 1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        check("ovr_cleared", overrun, 0);

        // Refill, then clear in the very cycle another frame is dropped.
        send_frame(8'h20, 1'b1, 1'b1);
        send_frame(8'h21, 1'b0, 1'b1);
        send_frame(8'h22, 1'b0, 1'b1);
        send_frame(8'h23, 1'b1, 1'b1);
        fork
            send_frame(8'h24, 1'b0, 1'b1);
            begin
                repeat (86) @(negedge clk);
                check("ovr2_pre", overrun, 0);
                clr_overrun = 1'b1;
                @(negedge clk);
                clr_overrun = 1'b0;
                check("ovr2_set_wins", overrun, 1);
            end
        join
        check("ovr2_count", fifo_count, 4);
        check("ovr2_head", bus.m_data, 8'h20);

        // Reset in the middle of the data bits.
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        repeat (3) @(negedge clk);
        check("mid_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_busy", busy, 0);
        check("mid_valid", bus.m_valid, 0);
        check("mid_count", fifo_count, 0);
        check("mid_overrun", overrun, 0);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        repeat (5) @(negedge clk);
        pops0 = n_pops;
        recv_check("post_rst", 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, lat);
        repeat (4) @(negedge clk);
        check("post_rst_pops", n_pops - pops0, 1);
        check("post_rst_count", fifo_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
